// File: rtl/buffer_datos_mem_externa_if.sv
// Push/pop bus of the external-memory word buffer.
// slave: the buffer; master: read controller plus filter stage.
interface buffer_datos_mem_externa_if #(
   parameter int DATA_WIDTH = 16
);
   logic                  save_mem_data;
   logic [DATA_WIDTH-1:0] dato_mem;
   logic                  buf_space_available;
   logic                  leer_dato;
   logic                  dato_valido;
   logic [DATA_WIDTH-1:0] dato_salida;

   modport slave (
      input  save_mem_data,
      input  dato_mem,
      input  leer_dato,
      output buf_space_available,
      output dato_valido,
      output dato_salida
   );

   modport master (
      output save_mem_data,
      output dato_mem,
      output leer_dato,
      input  buf_space_available,
      input  dato_valido,
      input  dato_salida
   );
endinterface

// File: rtl/buffer_datos_mem_externa.sv
// FWFT circular FIFO for words returned by external memory, with image-completion count.
// Optional sticky overflow/underflow flags: define BUF_MEM_ERRORES_EN.
module buffer_datos_mem_externa #(
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_BITS  = 4,
   parameter int MARGEN     = 1,
   parameter int CNT_WIDTH  = 21
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   limpiar,
   input  logic [CNT_WIDTH-1:0]   lecturas_totales_mem,
   buffer_datos_mem_externa_if.slave bus,
   output logic [ADDR_BITS:0]     nivel,
   output logic [CNT_WIDTH-1:0]   palabras_consumidas,
   output logic                   imagen_completa
`ifdef BUF_MEM_ERRORES_EN
   ,
   output logic                   error_desborde,
   output logic                   error_subdesborde
`endif
);

   localparam int DEPTH = 2**ADDR_BITS;
   localparam logic [ADDR_BITS:0]   NIVEL_LLENO = (ADDR_BITS+1)'(DEPTH);
   localparam logic [CNT_WIDTH-1:0] CNT_MAX     = '1;

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [ADDR_BITS-1:0]  wr_ptr;
   logic [ADDR_BITS-1:0]  rd_ptr;
   logic                  vacio;
   logic                  lleno;
   logic                  pop;
   logic                  push;
   logic [CNT_WIDTH-1:0]  cnt_nx;
   int                    libres;

   assign vacio = (nivel == '0);
   assign lleno = (nivel == NIVEL_LLENO);
   assign pop   = bus.leer_dato & ~vacio;
   // a full buffer still accepts a word when one leaves in the same cycle
   assign push  = bus.save_mem_data & (~lleno | pop);

   assign libres                  = DEPTH - int'(nivel);
   assign bus.buf_space_available = (libres > MARGEN);
   assign bus.dato_valido         = ~vacio;
   assign bus.dato_salida         = mem[rd_ptr];

   assign cnt_nx = (pop && palabras_consumidas != CNT_MAX)
                 ? palabras_consumidas + CNT_WIDTH'(1)
                 : palabras_consumidas;

   always_ff @(posedge clk) begin
      if (push && !reset && !limpiar)
         mem[wr_ptr] <= bus.dato_mem;
   end

   always_ff @(posedge clk) begin
      if (reset || limpiar) begin
         wr_ptr              <= '0;
         rd_ptr              <= '0;
         nivel               <= '0;
         palabras_consumidas <= '0;
         imagen_completa     <= 1'b0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + ADDR_BITS'(1);
         if (pop)
            rd_ptr <= rd_ptr + ADDR_BITS'(1);
         if (push && !pop)
            nivel <= nivel + (ADDR_BITS+1)'(1);
         else if (pop && !push)
            nivel <= nivel - (ADDR_BITS+1)'(1);
         palabras_consumidas <= cnt_nx;
         if (lecturas_totales_mem != '0 && cnt_nx == lecturas_totales_mem)
            imagen_completa <= 1'b1;
      end
   end

`ifdef BUF_MEM_ERRORES_EN
   always_ff @(posedge clk) begin
      if (reset || limpiar) begin
         error_desborde    <= 1'b0;
         error_subdesborde <= 1'b0;
      end else begin
         if (bus.save_mem_data && lleno && !pop)
            error_desborde <= 1'b1;
         if (bus.leer_dato && vacio)
            error_subdesborde <= 1'b1;
      end
   end
`endif

endmodule
